// File: rtl/alu_seq16_if.sv
// Bus bundle for alu_seq16: command handshake, result handshake and the
// byte-wide drive/return lines of the attached 8-bit ALU.
interface alu_seq16_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_x;
  logic [15:0] cmd_y;

  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_cin;
  logic [1:0]  alu_sel;
  logic [7:0]  alu_out;
  logic        alu_cout;

  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_carry;
  logic        res_zero;

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, res_ready, alu_out, alu_cout,
    output cmd_ready, alu_a, alu_b, alu_cin, alu_sel,
           res_valid, res_data, res_carry, res_zero
  );

  // Producer / consumer / ALU side.
  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, res_ready, alu_out, alu_cout,
    input  cmd_ready, alu_a, alu_b, alu_cin, alu_sel,
           res_valid, res_data, res_carry, res_zero
  );
endinterface

// File: rtl/alu_seq16.sv
// 16-bit operation sequencer: runs a command through an external 8-bit ALU
// as a low-byte pass then a high-byte pass, chaining carry/borrow between them.
module alu_seq16 (
  input  logic         clk,
  input  logic         rst,
  alu_seq16_if.slave   bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        cmd_fire;

  logic [1:0]  op_q;
  logic [15:0] x_q;
  logic [15:0] y_q;
  logic        carry_q;
  logic [15:0] res_q;
  logic        res_carry_q;
  logic        res_zero_q;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // cmd_ready depends on state only and res_valid is state only, so neither
  // handshake input reaches any output combinationally; a producer must hold
  // its command (and a consumer sees the result held) until the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          cmd_fire   = 1'b1;
          state_next = LO;
        end
      end
      LO:      state_next = HI;
      HI:      state_next = DONE;
      DONE: begin
        if (bus.res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= 2'b00;
      x_q         <= 16'h0000;
      y_q         <= 16'h0000;
      carry_q     <= 1'b0;
      res_q       <= 16'h0000;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
    end else begin
      if (cmd_fire) begin
        op_q <= bus.cmd_op;
        x_q  <= bus.cmd_x;
        y_q  <= bus.cmd_y;
      end
      if (state == LO) begin
        res_q[7:0] <= bus.alu_out;
        carry_q    <= bus.alu_cout;
      end
      if (state == HI) begin
        res_q[15:8] <= bus.alu_out;
        res_carry_q <= bus.alu_cout;
        // Low byte is already registered; zero is judged on the full word.
        res_zero_q  <= ({bus.alu_out, res_q[7:0]} == 16'h0000);
      end
    end
  end

  always_comb begin
    bus.alu_a   = 8'h00;
    bus.alu_b   = 8'h00;
    bus.alu_cin = 1'b0;
    bus.alu_sel = op_q;
    case (state)
      LO: begin
        bus.alu_a = x_q[7:0];
        bus.alu_b = y_q[7:0];
      end
      HI: begin
        bus.alu_a   = x_q[15:8];
        bus.alu_b   = y_q[15:8];
        // Only add/sub (op[1]==0) chain the low-byte carry/borrow.
        bus.alu_cin = op_q[1] ? 1'b0 : carry_q;
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.res_valid = (state == DONE);
  assign bus.res_data  = res_q;
  assign bus.res_carry = res_carry_q;
  assign bus.res_zero  = res_zero_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_alu_seq16.sv
// Self-checking bench for alu_seq16: behavioural 8-bit ALU on the bus,
// directed vector table, stall/reset sequences and randomized commands.
module tb_alu_seq16;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic [8:0] alu_t;

  alu_seq16_if bus ();

  alu_seq16 dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The attached ALU, as described by its contract.
  always_comb begin
    alu_t = 9'h000;
    case (bus.alu_sel)
      2'b00:   alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'h00, bus.alu_cin};
      2'b01:   alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {8'h00, bus.alu_cin};
      2'b10:   alu_t = {1'b0, bus.alu_a & bus.alu_b};
      default: alu_t = {1'b0, bus.alu_a | bus.alu_b};
    endcase
    bus.alu_out  = alu_t[7:0];
    bus.alu_cout = alu_t[8];
  end

  int n_chk = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] data;
    logic        carry;
    logic        zero;
    logic        cin_hi;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Whole-word reference: {carry, zero, data}.
  function automatic logic [17:0] model(input logic [1:0] op, input logic [15:0] x,
                                        input logic [15:0] y);
    logic [15:0] d;
    logic        c;
    int unsigned s;
    c = 1'b0;
    case (op)
      2'b00: begin
        s = int'(x) + int'(y);
        d = s[15:0];
        c = (s > 32'd65535);
      end
      2'b01: begin
        d = x - y;
        c = (x < y);
      end
      2'b10:   d = x & y;
      default: d = x | y;
    endcase
    return {c, (d == 16'h0000), d};
  endfunction

  function automatic logic cin_model(input logic [1:0] op, input logic [15:0] x,
                                     input logic [15:0] y);
    if (op == 2'b00) return (int'(x[7:0]) + int'(y[7:0])) > 255;
    if (op == 2'b01) return x[7:0] < y[7:0];
    return 1'b0;
  endfunction

  // Called at a negedge. Expected result is taken from exp_q. When hold_next is
  // set, a follow-up command is presented on cmd_valid during the DONE stall.
  task automatic run_cmd(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                         input int stall, input logic exp_cin,
                         input bit hold_next, input logic [1:0] nop,
                         input logic [15:0] nx, input logic [15:0] ny);
    logic [17:0] exp;
    int budget;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_x     = x;
    bus.cmd_y     = y;
    budget = 0;
    while (!bus.cmd_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("accept_timeout", 32'(budget < 20), 32'd1);
    @(negedge clk);  // N+1
    bus.cmd_valid = 1'b0;
    check("lo_state", 32'(dbg_state), 32'd1);
    check("lo_alu_a", 32'(bus.alu_a), 32'(x[7:0]));
    check("lo_alu_b", 32'(bus.alu_b), 32'(y[7:0]));
    check("lo_alu_cin", 32'(bus.alu_cin), 32'd0);
    check("lo_alu_sel", 32'(bus.alu_sel), 32'(op));
    check("lo_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);  // N+2
    check("hi_alu_a", 32'(bus.alu_a), 32'(x[15:8]));
    check("hi_alu_b", 32'(bus.alu_b), 32'(y[15:8]));
    check("hi_alu_cin", 32'(bus.alu_cin), 32'(exp_cin));
    check("hi_res_valid", 32'(bus.res_valid), 32'd0);
    @(negedge clk);  // N+3
    exp = exp_q.pop_front();
    check("done_res_valid", 32'(bus.res_valid), 32'd1);
    check("result", 32'({bus.res_carry, bus.res_zero, bus.res_data}), 32'(exp));
    for (int k = 0; k < stall; k++) begin
      if (hold_next) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = nop;
        bus.cmd_x     = nx;
        bus.cmd_y     = ny;
      end
      check("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
      check("stall_res_valid", 32'(bus.res_valid), 32'd1);
      check("stall_result", 32'({bus.res_carry, bus.res_zero, bus.res_data}), 32'(exp));
      check("stall_idle_alu_a", 32'(bus.alu_a), 32'd0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);  // N+4 (+stall)
    bus.res_ready = 1'b0;
    check("post_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("post_res_valid", 32'(bus.res_valid), 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [15:0] x;
    logic [15:0] y;

    vecs[0] = '{2'b00, 16'h12FF, 16'h0001, 16'h1300, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{2'b01, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{2'b01, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{2'b10, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2'b11, 16'h00FF, 16'h0100, 16'h01FF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{2'b00, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{2'b01, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0};

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_x     = 16'h0000;
    bus.cmd_y     = 16'h0000;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res", 32'({bus.res_carry, bus.res_zero, bus.res_data}), 32'd0);
    check("rst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_sel}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({vecs[i].carry, vecs[i].zero, vecs[i].data});
      run_cmd(vecs[i].op, vecs[i].x, vecs[i].y, 0, vecs[i].cin_hi, 1'b0, 2'b00, 16'h0, 16'h0);
    end

    // Five-cycle DONE stall with the next command already waiting.
    exp_q.push_back(model(2'b00, 16'h0101, 16'h0202));
    run_cmd(2'b00, 16'h0101, 16'h0202, 5, 1'b0, 1'b1, 2'b01, 16'h0300, 16'h0001);
    check("queued_accepted_state", 32'(bus.cmd_ready), 32'd1);
    exp_q.push_back(model(2'b01, 16'h0300, 16'h0001));
    run_cmd(2'b01, 16'h0300, 16'h0001, 0, 1'b1, 1'b0, 2'b00, 16'h0, 16'h0);

    // Reset while the high byte is in flight.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_x     = 16'hAAAA;
    bus.cmd_y     = 16'h5555;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_hi_state", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_state", 32'(dbg_state), 32'd0);
    check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    check("midrst_res", 32'({bus.res_carry, bus.res_zero, bus.res_data}), 32'd0);
    check("midrst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_sel}), 32'd0);
    exp_q.push_back({1'b0, 1'b0, 16'h0002});
    run_cmd(2'b00, 16'h0001, 16'h0001, 0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      x  = 16'($urandom);
      y  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) y = (op == 2'b01) ? x : 16'(-x);
      exp_q.push_back(model(op, x, y));
      run_cmd(op, x, y, $urandom_range(0, 3), cin_model(op, x, y), 1'b0, 2'b00, 16'h0, 16'h0);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq16.md
# alu_seq16

16-bit operation sequencer that sits directly upstream and downstream of the 8-bit `alu` datapath. It accepts a 16-bit command over a valid/ready handshake and drives the ALU with the low byte, then the high byte, chaining carry/borrow between the two passes. It captures the ALU results and returns a 16-bit result with carry and zero flags over a second valid/ready handshake. It adds no arithmetic of its own; all byte arithmetic is done by the attached ALU.

## Interface
- No parameters; data width is fixed at 16 bits, split into two 8-bit ALU passes.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command; high only in IDLE.
- `cmd_op`  in  2  ALU select: 00 add, 01 sub, 10 and, 11 or.
- `cmd_x`  in  16  first operand.
- `cmd_y`  in  16  second operand.
- `alu_a`  out  8  ALU operand a.
- `alu_b`  out  8  ALU operand b.
- `alu_cin`  out  1  ALU carry/borrow in.
- `alu_sel`  out  2  ALU select.
- `alu_out`  in  8  ALU result (combinational from the `alu_*` outputs).
- `alu_cout`  in  1  ALU carry out; 0 for and/or.
- `res_valid`  out  1  result present.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  16  result.
- `res_carry`  out  1  final carry (add) or borrow (sub); 0 for and/or.
- `res_zero`  out  1  1 when `res_data` == 0x0000.

## Operation
- ALU contract:
  - sel 00: out = a+b+cin mod 256; cout = carry.
  - sel 01: out = a−b−cin mod 256; cout = 1 on borrow.
  - sel 10/11: bitwise and/or; cout = 0.
- State machine IDLE → LO → HI → DONE → IDLE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`: register op, x, y; go to LO.
- LO:
  - Drive `alu_a`=x[7:0], `alu_b`=y[7:0], `alu_cin`=0, `alu_sel`=op.
  - At the edge: latch `alu_out` into res[7:0] and `alu_cout` into an internal carry register; go to HI.
- HI:
  - Drive `alu_a`=x[15:8], `alu_b`=y[15:8], `alu_sel`=op.
  - `alu_cin` = internal carry for add/sub; 0 for and/or.
  - At the edge: latch `alu_out` into res[15:8] and `alu_cout` into `res_carry`; compute `res_zero` from the full 16-bit value; go to DONE.
- DONE:
  - `res_valid`=1; `res_data`, `res_carry` and `res_zero` held stable.
  - On `res_ready`=1: go to IDLE.
  - `res_ready` low stalls indefinitely with all outputs held.
- ALU drive outside LO/HI: `alu_a`=`alu_b`=0, `alu_cin`=0, `alu_sel`=registered op.
- Commands are never accepted outside IDLE; `cmd_valid` there is ignored and must be held by the producer.

## Timing
- Reset values: state IDLE; `cmd_ready`=1; `res_valid`=0; `res_data`=0x0000; `res_carry`=0; `res_zero`=0; `alu_a`=`alu_b`=0; `alu_cin`=0; `alu_sel`=00.
- Reset asserted in any state, including mid-LO/HI and during a DONE stall, forces the reset values on the next edge. The in-flight command is dropped.
- Accept at edge N (cycle N is IDLE with the handshake):
  - LO during cycle N+1.
  - HI during cycle N+2.
  - `res_valid` high from cycle N+3.
- `res_ready` high in cycle N+3 completes the result; IDLE and `cmd_ready`=1 in cycle N+4.
- Maximum throughput: one command per 4 cycles.
- `cmd_ready` is a function of state only; `res_valid` is registered state only. No combinational path from `cmd_valid` or `res_ready` to any output.
- `alu_*` outputs are combinational from registered state and operands. `alu_out`/`alu_cout` are sampled at the end of the same cycle.

## Test plan
- Add 0x12FF + 0x0001 → `res_data`=0x1300, carry 0, zero 0. In cycle N+2, check `alu_cin`=1.
- Add 0xFFFF + 0x0001 → `res_data`=0x0000, carry 1, zero 1.
- Sub 0x1000 − 0x0001 → 0x0FFF, borrow 0. Sub 0x0000 − 0x0001 → 0xFFFF, borrow 1.
- And 0xF0F0 & 0x3C3C → 0x3030, carry 0. Or 0x00FF | 0x0100 → 0x01FF. In HI, check `alu_cin`=0.
- Hold `res_ready`=0 for 5 cycles in DONE:
  - `res_valid` and `res_data` stable throughout.
  - `cmd_ready` stays 0 while `cmd_valid` is held.
  - A second command is accepted only after the result handshake.
- Assert `rst` during HI → next cycle: IDLE, `res_valid`=0, all outputs at reset values. A fresh add 0x0001 + 0x0001 then returns 0x0002.
